// File: rtl/ps2_input_scheduler_pkg.sv
// ps2_input_scheduler_pkg: scan codes, encodings and per-player turn rules
package ps2_input_scheduler_pkg;

    localparam logic [7:0] P1_UP   = 8'h1D;
    localparam logic [7:0] P1_RT   = 8'h23;
    localparam logic [7:0] P1_DN   = 8'h1B;
    localparam logic [7:0] P1_LF   = 8'h1C;
    localparam logic [7:0] P2_UP   = 8'h75;
    localparam logic [7:0] P2_RT   = 8'h74;
    localparam logic [7:0] P2_DN   = 8'h72;
    localparam logic [7:0] P2_LF   = 8'h6B;
    localparam logic [7:0] SEL_0   = 8'h16;
    localparam logic [7:0] SEL_1   = 8'h1E;
    localparam logic [7:0] SEL_2   = 8'h26;
    localparam logic [7:0] SEL_3   = 8'h25;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BRK   = 8'hF0;

    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_RT = 2'd1;
    localparam logic [1:0] DIR_DN = 2'd2;
    localparam logic [1:0] DIR_LF = 2'd3;

    typedef enum logic [1:0] {MODE_MENU = 2'd0, MODE_PLAY = 2'd1, MODE_OVER = 2'd2} mode_t;
    typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] dir;
    } key_t;

    typedef struct packed {
        logic [1:0] dir;
        logic       pv;
        logic [1:0] pd;
    } player_t;

    localparam player_t P1_INIT = '{dir: DIR_RT, pv: 1'b0, pd: DIR_RT};
    localparam player_t P2_INIT = '{dir: DIR_LF, pv: 1'b0, pd: DIR_LF};

    function automatic key_t dir_key(input logic [7:0] code, input logic [7:0] up, rt, dn, lf);
        key_t k;
        k.vld = (code == up) || (code == rt) || (code == dn) || (code == lf);
        k.dir = (code == up) ? DIR_UP : (code == rt) ? DIR_RT : (code == dn) ? DIR_DN : DIR_LF;
        return k;
    endfunction

    function automatic logic [2:0] menu_index(input logic [7:0] code);
        return (code == SEL_0) ? 3'd1 : (code == SEL_1) ? 3'd2 :
               (code == SEL_2) ? 3'd3 : (code == SEL_3) ? 3'd4 : 3'd0;
    endfunction

    // A tick commits the old pending first; the key is then judged against the post-commit direction.
    function automatic player_t player_next(input player_t p, input logic tick, input key_t k);
        player_t n;
        n = p;
        if (tick && p.pv) n.dir = p.pd;
        if (tick) n.pv = 1'b0;
        if (k.vld && k.dir != (n.dir ^ 2'b10)) begin
            n.pv = (k.dir != n.dir);
            n.pd = k.dir;
        end
        return n;
    endfunction

endpackage

// File: rtl/ps2_event_decoder.sv
// ps2_event_decoder: PS/2 byte stream to registered make events with extended flag
module ps2_event_decoder
    import ps2_input_scheduler_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    output logic       evt_ext,
    output logic [7:0] evt_code
);

    dec_state_t state, state_n;
    logic       emit;

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        if (byte_valid) begin
            if (state == DEC_BRK || state == DEC_EXT_BRK) state_n = DEC_IDLE;
            else if (byte_data == K_EXT) state_n = DEC_EXT;
            else if (byte_data == K_BRK) state_n = (state == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
            else begin
                state_n = DEC_IDLE;
                emit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= DEC_IDLE;
            evt_valid <= 1'b0;
            evt_ext   <= 1'b0;
            evt_code  <= 8'h00;
        end else begin
            state     <= state_n;
            evt_valid <= emit;
            evt_ext   <= (state == DEC_EXT);
            evt_code  <= byte_data;
        end
    end

endmodule

// File: rtl/ps2_input_scheduler.sv
// ps2_input_scheduler: shares one PS/2 keyboard between the menu and two players
module ps2_input_scheduler
    import ps2_input_scheduler_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       game_tick,
    input  logic       game_over,
    output logic [2:0] menu_sel,
    output logic [1:0] mode,
    output logic       start_pulse,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir
);

    logic       evt_valid, evt_ext;
    logic [7:0] evt_code;

    ps2_event_decoder u_dec (
        .clock     (clock),
        .reset     (reset),
        .byte_valid(ps2_key_pressed),
        .byte_data (ps2_key_data),
        .evt_valid (evt_valid),
        .evt_ext   (evt_ext),
        .evt_code  (evt_code)
    );

    mode_t      st, st_n;
    logic [2:0] sel_r, sel_n, sel_key;
    logic       start_r, start_n, plain, is_enter, is_esc;
    player_t    p1, p2, p1_n, p2_n;
    key_t       k1, k2;

    // Player 1 and menu keys are plain codes; player 2 arrows only count when E0-prefixed.
    always_comb begin
        plain    = evt_valid && !evt_ext;
        k1       = dir_key(evt_code, P1_UP, P1_RT, P1_DN, P1_LF);
        k1.vld   = k1.vld && plain;
        k2       = dir_key(evt_code, P2_UP, P2_RT, P2_DN, P2_LF);
        k2.vld   = k2.vld && evt_valid && evt_ext;
        sel_key  = plain ? menu_index(evt_code) : 3'd0;
        is_enter = plain && evt_code == K_ENTER;
        is_esc   = plain && evt_code == K_ESC;
    end

    always_comb begin
        st_n    = st;
        sel_n   = sel_r;
        start_n = 1'b0;
        p1_n    = p1;
        p2_n    = p2;
        case (st)
            MODE_MENU: begin
                if (sel_key != 3'd0) sel_n = sel_key;
                else if (is_enter && sel_r != 3'd0) begin
                    st_n    = MODE_PLAY;
                    start_n = 1'b1;
                    p1_n    = P1_INIT;
                    p2_n    = P2_INIT;
                end
            end
            MODE_PLAY: begin
                if (game_over) begin
                    st_n    = MODE_OVER;
                    p1_n.pv = 1'b0;
                    p2_n.pv = 1'b0;
                end else if (is_esc) st_n = MODE_MENU;
                else begin
                    p1_n = player_next(p1, game_tick, k1);
                    p2_n = player_next(p2, game_tick, k2);
                end
            end
            MODE_OVER: if (is_enter || is_esc) st_n = MODE_MENU;
            default:   st_n = MODE_MENU;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= MODE_MENU;
            sel_r   <= 3'd0;
            start_r <= 1'b0;
            p1      <= P1_INIT;
            p2      <= P2_INIT;
        end else begin
            st      <= st_n;
            sel_r   <= sel_n;
            start_r <= start_n;
            p1      <= p1_n;
            p2      <= p2_n;
        end
    end

    assign menu_sel    = sel_r;
    assign mode        = st;
    assign start_pulse = start_r;
    assign p1_dir      = p1.dir;
    assign p2_dir      = p2.dir;

endmodule

// File: tb/tb_ps2_input_scheduler.sv
// tb_ps2_input_scheduler: directed stimulus checked against a behavioural scoreboard
module tb_ps2_input_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       game_tick = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] menu_sel;
    logic [1:0] mode;
    logic       start_pulse;
    logic [1:0] p1_dir, p2_dir;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_input_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_key_data   (ps2_key_data),
        .game_tick      (game_tick),
        .game_over      (game_over),
        .menu_sel       (menu_sel),
        .mode           (mode),
        .start_pulse    (start_pulse),
        .p1_dir         (p1_dir),
        .p2_dir         (p2_dir)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: prefix flags for the byte stream, plain integers for game state
    int   m_mode, m_sel, m_start;
    int   m_dir[2], m_pv[2], m_pd[2];
    bit   pfx_ext, pfx_brk, ev_v, ev_x;
    logic [7:0] ev_c;

    function automatic int key_dir(input int pl, input logic [7:0] c, input bit x);
        logic [7:0] tab [4];
        if (pl == 0) tab = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
        else         tab = '{8'h75, 8'h74, 8'h72, 8'h6B};
        if (x != (pl == 1)) return -1;
        for (int i = 0; i < 4; i++) if (tab[i] == c) return i;
        return -1;
    endfunction

    function automatic int sel_of(input logic [7:0] c, input bit x);
        logic [7:0] tab [4];
        tab = '{8'h16, 8'h1E, 8'h26, 8'h25};
        if (x) return 0;
        for (int i = 0; i < 4; i++) if (tab[i] == c) return i + 1;
        return 0;
    endfunction

    always @(posedge clock) begin : model
        int  k[2];
        int  s;
        bit  ent, esc;
        if (reset) begin
            m_mode = 0; m_sel = 0; m_start = 0;
            m_dir[0] = 1; m_dir[1] = 3; m_pv[0] = 0; m_pv[1] = 0;
            pfx_ext = 0; pfx_brk = 0; ev_v = 0;
        end else begin
            m_start = 0;
            k[0] = ev_v ? key_dir(0, ev_c, ev_x) : -1;
            k[1] = ev_v ? key_dir(1, ev_c, ev_x) : -1;
            s    = ev_v ? sel_of(ev_c, ev_x) : 0;
            ent  = ev_v && !ev_x && ev_c == 8'h5A;
            esc  = ev_v && !ev_x && ev_c == 8'h76;
            if (m_mode == 0) begin
                if (s != 0) m_sel = s;
                else if (ent && m_sel != 0) begin
                    m_mode = 1; m_start = 1;
                    m_dir[0] = 1; m_dir[1] = 3; m_pv[0] = 0; m_pv[1] = 0;
                end
            end else if (m_mode == 1) begin
                if (game_over) begin
                    m_mode = 2; m_pv[0] = 0; m_pv[1] = 0;
                end else if (esc) m_mode = 0;
                else for (int i = 0; i < 2; i++) begin
                    if (game_tick && m_pv[i] != 0) m_dir[i] = m_pd[i];
                    if (game_tick) m_pv[i] = 0;
                    if (k[i] >= 0 && k[i] != (m_dir[i] + 2) % 4) begin
                        m_pv[i] = (k[i] != m_dir[i]) ? 1 : 0;
                        m_pd[i] = k[i];
                    end
                end
            end else if (ent || esc) m_mode = 0;
            ev_v = 0;
            if (ps2_key_pressed) begin
                if (pfx_brk) begin pfx_brk = 0; pfx_ext = 0; end
                else if (ps2_key_data == 8'hE0) pfx_ext = 1;
                else if (ps2_key_data == 8'hF0) pfx_brk = 1;
                else begin
                    ev_v = 1; ev_x = pfx_ext; ev_c = ps2_key_data; pfx_ext = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("mode", mode, m_mode);
        check("menu_sel", menu_sel, m_sel);
        check("start_pulse", start_pulse, m_start);
        check("p1_dir", p1_dir, m_dir[0]);
        check("p2_dir", p2_dir, m_dir[1]);
    end

    task automatic cyc(input bit pr, input logic [7:0] d, input bit t, input bit go);
        ps2_key_pressed = pr;
        ps2_key_data    = d;
        game_tick       = t;
        game_over       = go;
        @(posedge clock);
        #2;
        ps2_key_pressed = 1'b0;
        game_tick       = 1'b0;
        game_over       = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        idle(); idle();
        reset = 1'b0;
        check("rst_mode", mode, 0);
        check("rst_sel", menu_sel, 0);
        check("rst_p1", p1_dir, 1);
        check("rst_p2", p2_dir, 3);
        check("rst_start", start_pulse, 0);

        send(8'h16);
        check("sel_not_yet", menu_sel, 0);
        idle();
        check("sel_1", menu_sel, 1);
        send(8'h5A); idle();
        check("play_mode", mode, 1);
        check("start_on", start_pulse, 1);
        idle();
        check("start_off", start_pulse, 0);
        check("play_p1", p1_dir, 1);
        check("play_p2", p2_dir, 3);

        send(8'h1D); idle(); tick();
        check("p1_up", p1_dir, 0);
        send(8'h1B); idle(); tick();
        check("p1_rev_rejected", p1_dir, 0);

        send(8'hE0); send(8'h72); idle();
        send(8'hE0); send(8'hF0); send(8'h72); idle();
        check("p2_before_tick", p2_dir, 3);
        tick();
        check("p2_down", p2_dir, 2);
        send(8'h74); idle(); tick();
        check("p2_bare_ignored", p2_dir, 2);

        send(8'h76); idle();
        check("esc_menu", mode, 0);
        check("esc_sel_kept", menu_sel, 1);
        send(8'h5A); idle(); idle();
        send(8'h1D); idle();
        cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        tick();
        check("tick_key_commit", p1_dir, 0);
        tick();
        check("tick_key_pending", p1_dir, 3);

        cyc(1'b1, 8'h76, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("over_wins", mode, 2);
        send(8'h1D); idle(); tick();
        check("over_frozen", p1_dir, 3);
        send(8'h5A); idle();
        check("over_to_menu", mode, 0);
        check("over_sel_kept", menu_sel, 1);

        send(8'hF0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        send(8'h5A); idle();
        check("post_rst_mode", mode, 0);
        check("post_rst_sel", menu_sel, 0);
        send(8'h26); idle();
        check("sel_3", menu_sel, 3);
        send(8'h25); send(8'h5A); idle();
        check("sel_4_play", mode, 1);
        check("sel_4", menu_sel, 4);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
